// File: rtl/led8x4_scan.sv
// led8x4_scan: four-digit multiplexed 7-segment driver with dead-time,
// double-buffered digit data and optional leading-zero blanking.
module led8x4_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic [3:0]  dp_in,
    input  logic        lz_blank,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  dig_n,
    output logic        frame_start
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [0:0] BLANK = 1'b0;
    localparam logic [0:0] SHOW  = 1'b1;
    logic [0:0]  state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        run_q, run_d;
    logic [15:0] sh_data_q, sh_data_d, disp_data_q, disp_data_d;
    logic [3:0]  sh_dp_q, sh_dp_d, disp_dp_q, disp_dp_d;
    logic [6:0]  seg_d, hex;
    logic        dp_d, fs_d, load, lz_hide;
    logic [3:0]  dig_d, nib;
    // The first edge after reset release only arms the counter so the
    // opening dead-time spans a full BLANK_CYC cycles of observable output.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + 1'b1;
        run_d   = 1'b1;
        if (!run_q) begin
            cnt_d = cnt_q;
        end else if (state_q == SHOW && cnt_q == CW'(SCAN_DIV - BLANK_CYC - 1)) begin
            state_d = BLANK;
            cnt_d   = '0;
        end else if (state_q == BLANK && cnt_q == CW'(BLANK_CYC - 1)) begin
            state_d = SHOW;
            idx_d   = idx_q + 2'd1;
            cnt_d   = '0;
        end
        load        = state_q == BLANK && state_d == SHOW && idx_d == 2'd0;
        sh_data_d   = wr_en ? wr_data : sh_data_q;
        sh_dp_d     = wr_en ? dp_in : sh_dp_q;
        disp_data_d = load ? sh_data_q : disp_data_q;
        disp_dp_d   = load ? sh_dp_q : disp_dp_q;
    end
    always_comb begin
        nib = disp_data_d[{idx_d, 2'b00} +: 4];
        case (nib)
            4'h0: hex = 7'h40;
            4'h1: hex = 7'h79;
            4'h2: hex = 7'h24;
            4'h3: hex = 7'h30;
            4'h4: hex = 7'h19;
            4'h5: hex = 7'h12;
            4'h6: hex = 7'h02;
            4'h7: hex = 7'h78;
            4'h8: hex = 7'h00;
            4'h9: hex = 7'h10;
            4'hA: hex = 7'h08;
            4'hB: hex = 7'h03;
            4'hC: hex = 7'h46;
            4'hD: hex = 7'h21;
            4'hE: hex = 7'h06;
            default: hex = 7'h0E;
        endcase
        lz_hide = lz_blank && idx_d != 2'd0 && (disp_data_d >> {idx_d, 2'b00}) == 16'h0;
        seg_d   = (state_d == SHOW && !lz_hide) ? hex : 7'h7F;
        dig_d   = (state_d == SHOW) ? ~(4'b0001 << idx_d) : 4'hF;
        dp_d    = (state_d == SHOW) ? ~disp_dp_d[idx_d] : 1'b1;
        fs_d    = load;
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= BLANK;
            idx_q       <= 2'd3;
            cnt_q       <= '0;
            run_q       <= 1'b0;
            sh_data_q   <= '0;
            sh_dp_q     <= '0;
            disp_data_q <= '0;
            disp_dp_q   <= '0;
            seg_n       <= 7'h7F;
            dp_n        <= 1'b1;
            dig_n       <= 4'hF;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            sh_data_q   <= sh_data_d;
            sh_dp_q     <= sh_dp_d;
            disp_data_q <= disp_data_d;
            disp_dp_q   <= disp_dp_d;
            seg_n       <= seg_d;
            dp_n        <= dp_d;
            dig_n       <= dig_d;
            frame_start <= fs_d;
        end
    end
endmodule

// File: tb/tb_led8x4_scan.sv
// tb_led8x4_scan: directed and random stimulus against a timeline model of
// the scanner (position since reset release -> slot, blank, frame boundary).
module tb_led8x4_scan;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FR = 4 * SD;
    logic        Clk = 1'b0, Rst = 1'b1, wr_en = 1'b0, lz_blank = 1'b0;
    logic [15:0] wr_data = '0;
    logic [3:0]  dp_in = '0;
    logic [6:0]  seg_n;
    logic        dp_n, frame_start;
    logic [3:0]  dig_n;
    int checks = 0, failures = 0;
    int p = -1, q = -1, e_slot = -1;
    logic [15:0] m_sh = '0, m_disp = '0;
    logic [3:0]  m_shdp = '0, m_dispdp = '0;
    logic [6:0]  e_seg;
    logic        e_dp, e_fs;
    logic [3:0]  e_dig;
    logic [6:0]  hex [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    led8x4_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .Clk(Clk), .Rst(Rst), .wr_en(wr_en), .wr_data(wr_data), .dp_in(dp_in),
        .lz_blank(lz_blank), .seg_n(seg_n), .dp_n(dp_n), .dig_n(dig_n),
        .frame_start(frame_start)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model from the inputs sampled at the edge, then compare.
    task automatic step();
        @(posedge Clk);
        e_seg = 7'h7F; e_dp = 1'b1; e_dig = 4'hF; e_fs = 1'b0; e_slot = -1;
        if (Rst) begin
            p = -1; q = -1;
            m_sh = '0; m_shdp = '0; m_disp = '0; m_dispdp = '0;
        end else begin
            p = (p < 0) ? 0 : p + 1;
            q = p - BC;
            if (q >= 0 && q % FR == 0) begin
                m_disp = m_sh; m_dispdp = m_shdp;
            end
            if (wr_en) begin
                m_sh = wr_data; m_shdp = dp_in;
            end
            if (q >= 0 && q % SD < SD - BC) begin
                e_slot = (q / SD) % 4;
                e_dig  = ~(4'b0001 << e_slot);
                e_dp   = ~m_dispdp[e_slot];
                e_seg  = (lz_blank && e_slot != 0 && (m_disp >> (4 * e_slot)) == 16'h0)
                         ? 7'h7F : hex[m_disp[4*e_slot +: 4]];
                e_fs   = (q % FR == 0);
            end
        end
        #1;
        chk("model", {3'b000, seg_n, dp_n, dig_n, frame_start}, {3'b000, e_seg, e_dp, e_dig, e_fs});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write(input logic [15:0] d, input logic [3:0] dp);
        wr_en = 1'b1; wr_data = d; dp_in = dp;
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_slot(input int s);
        logic [3:0] w;
        int n;
        w = ~(4'b0001 << s);
        n = 0;
        while (dig_n !== w && n < 2 * FR) begin
            step(); n++;
        end
        chk("wait_slot", {12'h0, dig_n}, {12'h0, w});
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < 2 * FR) begin
            step(); n++;
        end
        chk("wait_fs", {15'h0, frame_start}, 16'h1);
    endtask

    initial begin
        int gap, seen;
        logic [3:0] last;
        run(3);
        chk("reset_outs", {3'b000, seg_n, dp_n, dig_n, frame_start}, {3'b000, 7'h7F, 1'b1, 4'hF, 1'b0});
        Rst = 1'b0;
        step(); chk("rel_blank0", {12'h0, dig_n}, 16'hF);
        step(); chk("rel_blank1", {12'h0, dig_n}, 16'hF);
        step();
        chk("first_show", {12'h0, dig_n}, 16'hE);
        chk("first_seg", {9'h0, seg_n}, 16'h40);
        chk("first_fs", {15'h0, frame_start}, 16'h1);
        step(); chk("fs_once", {15'h0, frame_start}, 16'h0);
        run(5); chk("slot0_end", {12'h0, dig_n}, 16'hF);

        write(16'h1A8F, 4'b0100);
        run(2 * FR);
        wait_slot(0); chk("d0_F", {9'h0, seg_n}, 16'h0E);
        wait_slot(1); chk("d1_8", {9'h0, seg_n}, 16'h00);
        wait_slot(2); chk("d2_A", {9'h0, seg_n}, 16'h08); chk("d2_dp", {15'h0, dp_n}, 16'h0);
        wait_slot(3); chk("d3_1", {9'h0, seg_n}, 16'h79); chk("d3_dp", {15'h0, dp_n}, 16'h1);

        lz_blank = 1'b1;
        write(16'h0005, 4'b0000);
        run(2 * FR);
        wait_slot(3); chk("lz_d3", {9'h0, seg_n}, 16'h7F);
        wait_slot(1); chk("lz_d1", {9'h0, seg_n}, 16'h7F);
        wait_slot(0); chk("lz_d0_5", {9'h0, seg_n}, 16'h12);
        write(16'h0000, 4'b0001);
        run(2 * FR);
        wait_slot(0); chk("lz_d0_0", {9'h0, seg_n}, 16'h40); chk("lz_dp", {15'h0, dp_n}, 16'h0);
        wait_slot(2); chk("lz_d2", {9'h0, seg_n}, 16'h7F);

        lz_blank = 1'b0;
        wait_slot(2);
        write(16'h1111, 4'b0000);
        wait_fs();
        write(16'h2222, 4'b0000);
        wait_slot(1); chk("dbuf_1111", {9'h0, seg_n}, 16'h79);
        wait_fs();
        wait_slot(1); chk("dbuf_2222", {9'h0, seg_n}, 16'h24);

        wait_slot(1);
        write(16'h3333, 4'b1111);
        Rst = 1'b1;
        step();
        chk("midrst_outs", {3'b000, seg_n, dp_n, dig_n, frame_start}, {3'b000, 7'h7F, 1'b1, 4'hF, 1'b0});
        Rst = 1'b0;
        run(2);
        chk("rst_blank", {12'h0, dig_n}, 16'hF);
        step();
        chk("rst_show", {12'h0, dig_n}, 16'hE);
        chk("rst_disp0", {9'h0, seg_n}, 16'h40);
        chk("rst_fs", {15'h0, frame_start}, 16'h1);
        run(FR);
        chk("rst_shadow", {12'h0, dig_n}, 16'hE);
        chk("rst_shadow_seg", {9'h0, seg_n}, 16'h40);

        gap = 0; seen = 0; last = dig_n;
        for (int i = 0; i < 1000 * FR; i++) begin
            if ($urandom_range(0, 40) == 0) begin
                wr_en = 1'b1; wr_data = 16'($urandom); dp_in = 4'($urandom);
            end else wr_en = 1'b0;
            if ($urandom_range(0, 200) == 0) lz_blank = ~lz_blank;
            if ($urandom_range(0, 30) == 0) wr_data = 16'($urandom) & 16'h00FF;
            step();
            chk("onehot", {15'h0, 1'($countones(~dig_n) <= 1)}, 16'h1);
            if (dig_n == 4'hF) gap++;
            else begin
                if (last == 4'hF && seen != 0) chk("gap", 16'(gap), 16'(BC));
                seen = 1;
                gap = 0;
            end
            last = dig_n;
        end
        wr_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/led8x4_scan.md
LED8X4_SCAN -- requirements
Module: led8x4_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles per digit slot (1 ms at 50 MHz).
REQ-002 SHALL have parameter BLANK_CYC, default 500, dead-time cycles at the end of each slot; legal range 1 <= BLANK_CYC < SCAN_DIV.
REQ-003 SHALL have port Clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port Rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  single-cycle strobe capturing wr_data and dp_in.
REQ-006 SHALL have port wr_data  input  16  four hex digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3 (leftmost).
REQ-007 SHALL have port dp_in  input  4  per-digit decimal point, 1 = lit; bit i belongs to digit i.
REQ-008 SHALL have port lz_blank  input  1  leading-zero blanking enable, sampled every cycle.
REQ-009 SHALL have port seg_n  output  7  active-low segments, [0]=a through [6]=g.
REQ-010 SHALL have port dp_n  output  1  active-low decimal point.
REQ-011 SHALL have port dig_n  output  4  active-low digit enables; bit i drives digit i.
REQ-012 SHALL have port frame_start  output  1  one-cycle pulse when digit 0 slot begins.

Function
REQ-013 SHALL hold a shadow register (16-bit data, 4-bit dp) loaded on any cycle with wr_en=1; the last write wins.
REQ-014 SHALL hold a display register loaded from the shadow only on the edge entering SHOW with idx=0; a write in that same cycle lands in the shadow and shows next frame.
REQ-015 SHALL implement FSM {SHOW, BLANK}, 2-bit digit index idx, and slot counter cnt.
REQ-016 SHOW SHALL last SCAN_DIV-BLANK_CYC cycles, then enter BLANK with cnt=0.
REQ-017 BLANK SHALL last BLANK_CYC cycles, then enter SHOW with idx=idx+1 mod 4 (3 wraps to 0) and cnt=0.
REQ-018 Frame period SHALL be exactly 4*SCAN_DIV cycles.
REQ-019 All outputs SHALL be registered and change on the same edge as the state/idx registers.
REQ-020 In SHOW, dig_n SHALL have only bit idx low; in BLANK, dig_n=4'hF, seg_n=7'h7F, dp_n=1.
REQ-021 In SHOW, seg_n SHALL be the active-low hex decode of display nibble idx: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E.
REQ-022 In SHOW, dp_n SHALL equal ~display_dp[idx], independent of blanking.
REQ-023 With lz_blank=1, digit i (i=3..1) SHALL show seg_n=7'h7F when its nibble and all higher nibbles are zero; digit 0 SHALL never be blanked.
REQ-024 frame_start SHALL be 1 for exactly the one cycle in which SHOW with idx=0 is first presented.

Reset
REQ-025 While Rst=1: state=BLANK, idx=3, cnt=0, shadow and display = 0, seg_n=7'h7F, dp_n=1, dig_n=4'hF, frame_start=0.
REQ-026 Reset asserted mid-slot SHALL take effect on the next edge, aborting the slot and discarding pending shadow data.
REQ-027 After release, the first SHOW (idx=0, with frame_start pulse and shadow transfer) SHALL begin BLANK_CYC edges after the first edge sampling Rst=0.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-028 Reset, then release -> dig_n=4'hF for 2 cycles; then dig_n=4'b1110, seg_n=0x40, frame_start pulses once; 6 cycles later all blank.
REQ-029 Write 16'h1A8F, dp_in=4'b0100, and wait for frame boundary -> over each 32-cycle frame: d0 seg_n=0x0E, d1 seg_n=0x00, d2 seg_n=0x08 with dp_n=0, d3 seg_n=0x79.
REQ-030 lz_blank=1, write 16'h0005 -> d3, d2, d1 seg_n=7'h7F; d0 seg_n=0x12. Write 16'h0000 -> d0 shows 0x40.
REQ-031 Write 16'h1111 during digit 2 SHOW, then 16'h2222 in the frame_start cycle -> next frame shows 1111; the following frame shows 2222.
REQ-032 Assert Rst for 1 cycle during digit 1 SHOW -> next edge all outputs are at reset values, display=0; restart timing per REQ-027.
REQ-033 Over 1000 frames -> never more than one dig_n bit low, and dig_n=4'hF for exactly 2 cycles between consecutive digits.
